// File: rtl/video_timing_rx.sv
// Receive-side video timing recovery: rebuilds column/row/linear address from a
// strobed de/vsync stream and checks line and frame geometry.
module video_timing_rx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              pixel_en,
    input  logic              de,
    input  logic              vsync,
    output logic              pixel_valid,
    output logic [9:0]        pix_col,
    output logic [9:0]        pix_row,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              line_done,
    output logic              frame_done,
    output logic              locked,
    output logic              err_line,
    output logic              err_frame
);

    localparam logic [9:0] H_MAX = 10'(H_ACTIVE);
    localparam logic [9:0] V_MAX = 10'(V_ACTIVE);

    typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} state_t;

    state_t            state, next_state;
    logic [9:0]        col, row, next_col, next_row;
    logic [ADDR_W-1:0] addr, next_addr;
    logic              prev_de, prev_vsync;
    logic              vsync_rise, de_fall;

    logic              next_pixel_valid, next_line_done, next_frame_done;
    logic              next_err_line, next_err_frame, next_locked;
    logic [9:0]        next_pix_col, next_pix_row;
    logic [ADDR_W-1:0] next_pix_addr;

    assign vsync_rise = vsync & ~prev_vsync;
    assign de_fall    = ~de & prev_de;

    // Events on one beat are resolved in order: line check, frame check, pixel.
    always_comb begin
        next_state       = state;
        next_col         = col;
        next_row         = row;
        next_addr        = addr;
        next_pixel_valid = 1'b0;
        next_line_done   = 1'b0;
        next_frame_done  = 1'b0;
        next_err_line    = 1'b0;
        next_err_frame   = 1'b0;
        next_locked      = locked;
        next_pix_col     = pix_col;
        next_pix_row     = pix_row;
        next_pix_addr    = pix_addr;

        if (pixel_en) begin
            if (state != SEEK && de_fall) begin
                if (col == H_MAX) begin
                    if (row == V_MAX) begin
                        next_err_frame = 1'b1;
                        next_locked    = 1'b0;
                        next_state     = SEEK;
                    end else begin
                        next_line_done = 1'b1;
                        next_row       = row + 10'd1;
                        next_col       = '0;
                    end
                end else begin
                    next_err_line = 1'b1;
                    next_locked   = 1'b0;
                    next_state    = SEEK;
                end
            end

            if (vsync_rise) begin
                if (next_state == SEEK) begin
                    next_state = ACQUIRE;
                end else if (next_row == V_MAX) begin
                    next_frame_done = 1'b1;
                    next_locked     = 1'b1;
                    next_state      = LOCKED;
                end else begin
                    next_err_frame = 1'b1;
                    next_locked    = 1'b0;
                    next_state     = ACQUIRE;
                end
                next_col  = '0;
                next_row  = '0;
                next_addr = '0;
            end

            if (next_state != SEEK && de) begin
                if (next_col < H_MAX) begin
                    next_pixel_valid = 1'b1;
                    next_pix_col     = next_col;
                    next_pix_row     = next_row;
                    next_pix_addr    = next_addr;
                    next_col         = next_col + 10'd1;
                    next_addr        = next_addr + ADDR_W'(1);
                end else begin
                    next_err_line = 1'b1;
                    next_locked   = 1'b0;
                    next_state    = SEEK;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= SEEK;
            col         <= '0;
            row         <= '0;
            addr        <= '0;
            prev_de     <= 1'b0;
            prev_vsync  <= 1'b0;
            pixel_valid <= 1'b0;
            pix_col     <= '0;
            pix_row     <= '0;
            pix_addr    <= '0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            state       <= next_state;
            col         <= next_col;
            row         <= next_row;
            addr        <= next_addr;
            if (pixel_en) begin
                prev_de    <= de;
                prev_vsync <= vsync;
            end
            pixel_valid <= next_pixel_valid;
            pix_col     <= next_pix_col;
            pix_row     <= next_pix_row;
            pix_addr    <= next_pix_addr;
            line_done   <= next_line_done;
            frame_done  <= next_frame_done;
            locked      <= next_locked;
            err_line    <= next_err_line;
            err_frame   <= next_err_frame;
        end
    end

endmodule

// File: tb/tb_video_timing_rx.sv
// Scoreboard bench for video_timing_rx on a 4x3 geometry: directed streams push
// expected events, a negedge monitor pops and compares them.
module tb_video_timing_rx;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          n_rst, pixel_en, de, vsync;
    logic          pixel_valid, line_done, frame_done, locked, err_line, err_frame;
    logic [9:0]    pix_col, pix_row;
    logic [AW-1:0] pix_addr;

    always #5 clk = ~clk;

    video_timing_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .pixel_en(pixel_en), .de(de), .vsync(vsync),
        .pixel_valid(pixel_valid), .pix_col(pix_col), .pix_row(pix_row),
        .pix_addr(pix_addr), .line_done(line_done), .frame_done(frame_done),
        .locked(locked), .err_line(err_line), .err_frame(err_frame)
    );

    typedef struct packed {
        logic pv, ld, fd, el, ef, lk;
        logic [9:0] col, row;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          beat_q = 1'b0;
    logic [9:0]    sh_col = '0, sh_row = '0;
    logic [AW-1:0] sh_addr = '0;
    logic          sh_lk = 1'b0;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    function automatic void push(input logic pv, ld, fd, el, ef, lk, input int c, r, a);
        exp_t e;
        e.pv = pv; e.ld = ld; e.fd = fd; e.el = el; e.ef = ef; e.lk = lk;
        e.col = 10'(c); e.row = 10'(r); e.addr = AW'(a);
        exp_q.push_back(e);
    endfunction

    always @(posedge clk) beat_q <= pixel_en;

    // Pulses are matched against the queue; quiet cycles must hold the last pixel and lock.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!n_rst) begin
            sh_col = '0; sh_row = '0; sh_addr = '0; sh_lk = 1'b0;
        end else if (pixel_valid | line_done | frame_done | err_line | err_frame) begin
            check_output("pulse_after_beat", 64'(beat_q), 64'(1));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event at %0t: got pv=%b ld=%b fd=%b el=%b ef=%b, expected none",
                         $time, pixel_valid, line_done, frame_done, err_line, err_frame);
            end else begin
                e = exp_q.pop_front();
                if (e.pv) begin
                    sh_col = e.col; sh_row = e.row; sh_addr = e.addr;
                end
                sh_lk = e.lk;
                check_output("event",
                    64'({pixel_valid, line_done, frame_done, err_line, err_frame, locked, pix_col, pix_row, pix_addr}),
                    64'({e.pv, e.ld, e.fd, e.el, e.ef, e.lk, sh_col, sh_row, sh_addr}));
            end
        end else begin
            check_output("hold", 64'({locked, pix_col, pix_row, pix_addr}),
                         64'({sh_lk, sh_col, sh_row, sh_addr}));
        end
    end

    task automatic apply_stimulus(input logic d, input logic v, input int gap);
        pixel_en = 1'b1; de = d; vsync = v;
        @(posedge clk); #2;
        pixel_en = 1'b0;
        repeat (gap) begin @(posedge clk); #2; end
    endtask

    task automatic frame_start(input logic fd, input logic ef, input logic lk, input int gap);
        if (fd || ef) push(0, 0, fd, 0, ef, lk, 0, 0, 0);
        apply_stimulus(1'b0, 1'b1, gap);
        apply_stimulus(1'b0, 1'b0, gap);
    endtask

    task automatic good_line(input int r, input logic lk, input int gap);
        for (int c = 0; c < H; c++) begin
            push(1, 0, 0, 0, 0, lk, c, r, r * H + c);
            apply_stimulus(1'b1, 1'b0, gap);
        end
        push(0, 1, 0, 0, 0, lk, 0, 0, 0);
        apply_stimulus(1'b0, 1'b0, gap);
        apply_stimulus(1'b0, 1'b0, gap);
    endtask

    task automatic good_frame(input logic lk, input int gap);
        for (int r = 0; r < V; r++) good_line(r, lk, gap);
        frame_start(1'b1, 1'b0, 1'b1, gap);
    endtask

    initial begin
        n_rst = 1'b0; pixel_en = 1'b0; de = 1'b0; vsync = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_output("reset_outputs",
            64'({pixel_valid, line_done, frame_done, err_line, err_frame, locked, pix_col, pix_row, pix_addr}), 64'(0));
        n_rst = 1'b1;
        @(posedge clk); #2;

        $display("[TB] first frame acquires lock");
        frame_start(1'b0, 1'b0, 1'b0, 0);
        good_frame(1'b0, 0);

        $display("[TB] same stream with a beat every third cycle");
        good_frame(1'b1, 2);

        $display("[TB] short line drops lock until next vsync");
        good_line(0, 1'b1, 0);
        for (int c = 0; c < 3; c++) begin
            push(1, 0, 0, 0, 0, 1, c, 1, 4 + c);
            apply_stimulus(1'b1, 1'b0, 0);
        end
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply_stimulus(1'b0, 1'b0, 0);
        for (int c = 0; c < H; c++) apply_stimulus(1'b1, 1'b0, 0);
        apply_stimulus(1'b0, 1'b0, 0);
        frame_start(1'b0, 1'b0, 1'b0, 0);
        good_frame(1'b0, 0);

        $display("[TB] long line errors on the fifth beat");
        for (int c = 0; c < H; c++) begin
            push(1, 0, 0, 0, 0, 1, c, 0, c);
            apply_stimulus(1'b1, 1'b0, 0);
        end
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 0);
        apply_stimulus(1'b0, 1'b0, 0);
        frame_start(1'b0, 1'b0, 1'b0, 0);
        good_frame(1'b0, 0);

        $display("[TB] short frame restarts in acquire");
        good_line(0, 1'b1, 0);
        good_line(1, 1'b1, 0);
        frame_start(1'b0, 1'b1, 1'b0, 0);
        good_frame(1'b0, 0);

        $display("[TB] reset mid-line while locked");
        push(1, 0, 0, 0, 0, 1, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 0);
        push(1, 0, 0, 0, 0, 1, 1, 0, 1);
        apply_stimulus(1'b1, 1'b0, 0);
        @(posedge clk); #2;
        de = 1'b1;
        n_rst = 1'b0;
        #1;
        check_output("async_reset_outputs",
            64'({pixel_valid, line_done, frame_done, err_line, err_frame, locked, pix_col, pix_row, pix_addr}), 64'(0));
        @(posedge clk); #2;
        n_rst = 1'b1;
        for (int c = 0; c < H; c++) apply_stimulus(1'b1, 1'b0, 0);
        apply_stimulus(1'b0, 1'b0, 0);
        frame_start(1'b0, 1'b0, 1'b0, 0);
        good_frame(1'b0, 0);

        $display("[TB] de fall coinciding with vsync completes the frame");
        good_line(0, 1'b1, 0);
        good_line(1, 1'b1, 0);
        for (int c = 0; c < H; c++) begin
            push(1, 0, 0, 0, 0, 1, c, 2, 8 + c);
            apply_stimulus(1'b1, 1'b0, 0);
        end
        push(0, 1, 1, 0, 0, 1, 0, 0, 0);
        apply_stimulus(1'b0, 1'b1, 0);
        apply_stimulus(1'b0, 1'b0, 0);

        repeat (4) @(posedge clk);
        #2;
        check_output("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
